mod_addsub_serial: RTL and testbench
====================================

MOD_ADDSUB_SERIAL -- requirements
Module: mod_addsub_serial

Interface
- REQ-001 SHALL have parameter WIDTH, default 256: operand and result width in bits.
- REQ-002 SHALL have parameter LIMB, default 64: limb width processed per cycle. WIDTH % LIMB == 0 is required; N = WIDTH/LIMB.
- REQ-003 SHALL have parameter MODULUS [WIDTH-1:0], default the secp256k1 prime p = FFFFFFFF...FFFFFFFE FFFFFC2F (hex).
- REQ-004 SHALL have ports as follows:
  - clk  in  1: single clock, rising edge.
  - reset  in  1: synchronous, active-high.
  - in_valid  in  1: operand set valid.
  - in_ready  out  1: block can accept operands.
  - op  in  1: 0 = add, 1 = subtract.
  - x  in  WIDTH: operand, precondition x < MODULUS.
  - y  in  WIDTH: operand, precondition y < MODULUS.
  - out_valid  out  1: result valid.
  - out_ready  in  1: consumer accepts result.
  - result  out  WIDTH: (x op y) mod MODULUS.
  - busy  out  1: state other than IDLE.

Function
- REQ-005 SHALL implement the FSM IDLE -> PASS1 -> PASS2 -> DONE -> IDLE.
- REQ-006 SHALL assert in_ready only in IDLE; acceptance occurs when in_valid && in_ready. On acceptance it SHALL register x, y and op, clear the limb counter and carry, and enter PASS1.
- REQ-007 PASS1 SHALL run N cycles, processing limb k on counter value k, LSB limb first.
  - Add: s = x + y, with carry propagated across limbs.
  - Sub: s = x - y, with borrow propagated across limbs.
  - The final carry/borrow c1 SHALL be kept.
- REQ-008 PASS2 SHALL run N cycles.
  - Add: t = s - MODULUS, final borrow b2.
  - Sub: t = s + MODULUS.
- REQ-009 Final selection:
  - Add: result = t if (c1 || !b2), else s.
  - Sub: result = t if c1 (borrow), else s.
- REQ-010 Latency: out_valid SHALL rise exactly 2N+1 cycles after the acceptance edge (9 cycles for defaults).
- REQ-011 In DONE, out_valid SHALL be 1 and result SHALL be held stable until out_valid && out_ready. The next state SHALL then be IDLE, with out_valid 0 in that cycle.
- REQ-012 in_valid outside IDLE SHALL be ignored; operands SHALL not be sampled and the state SHALL not change.
- REQ-013 Limb counter SHALL wrap from N-1 to 0 on the PASS1->PASS2 and PASS2->DONE transitions.
- REQ-014 Operands violating x, y < MODULUS SHALL produce an unspecified result but SHALL still complete with the normal latency and handshake.

Reset
- REQ-015 While reset = 1 at a clk edge, the block SHALL:
  - set state to IDLE;
  - set out_valid = 0, busy = 0, in_ready = 1 (from the following cycle);
  - set result = 0;
  - clear counter and carries.
- REQ-016 Reset in any state, including mid-PASS1/PASS2 or DONE with out_ready low, SHALL abort the operation with no output produced.

Configuration
- REQ-017 With macro MOD_ADDSUB_SUB_EN defined, the op input and the subtract path SHALL be compiled in.
- REQ-018 Without MOD_ADDSUB_SUB_EN, op SHALL be ignored, only addition SHALL be implemented, and no subtract logic SHALL be present. Latency and handshake SHALL be unchanged.

Structure
- REQ-019 Shared package mod_arith_pkg SHALL hold:
  - SECP256K1_P constant;
  - op encoding (OP_ADD, OP_SUB);
  - FSM state typedef.
- REQ-020 SHALL instantiate one combinational sub-module limb_addsub (LIMB-bit add/subtract with carry-in/carry-out), reused by both passes.

Verification
- REQ-021 add x=1, y=2 -> result 3, out_valid at accept+9.
- REQ-022 add x=p-1, y=2 -> result 1; add x=p-1, y=1 -> result 0.
- REQ-023 sub x=0, y=1 -> result p-1; sub x=y=0x1234 -> result 0 (requires MOD_ADDSUB_SUB_EN).
- REQ-024 out_ready low for 5 cycles after out_valid -> result and out_valid stable, in_ready 0 throughout. Result accepted on first out_ready=1, then in_ready=1 next cycle.
- REQ-025 in_valid pulsed with different operands during PASS1 -> ignored, original result delivered.
- REQ-026 reset asserted during cycle 3 of PASS1 -> next cycle state IDLE, out_valid 0, in_ready 1. A subsequent add 5+7 -> 12 with normal latency.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the serial modular add/subtract block.
package mod_arith_pkg;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS1,
        ST_PASS2,
        ST_DONE
    } state_t;

endpackage

// File: rtl/limb_addsub.sv
// One LIMB-bit add/subtract slice. cin/cout are a carry when sub=0 and a borrow when sub=1.
module limb_addsub #(
    parameter int LIMB = 64
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            sub,
    input  logic            cin,
    output logic [LIMB-1:0] sum,
    output logic            cout
);

    logic [LIMB:0] raw;

    // a - b - borrow == a + ~b + ~borrow; the raw carry out is the inverted borrow.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{LIMB{1'b0}}, (sub ? ~cin : cin)};
        sum  = raw[LIMB-1:0];
        cout = raw[LIMB] ^ sub;
    end

endmodule

// File: rtl/mod_addsub_serial.sv
// Limb-serial (x +/- y) mod MODULUS: one pass for the raw sum/difference, one for the correction.
// Subtraction is compiled in only when MOD_ADDSUB_SUB_EN is defined.
module mod_addsub_serial
    import mod_arith_pkg::*;
#(
    parameter int               WIDTH   = 256,
    parameter int               LIMB    = 64,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(SECP256K1_P)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int N  = WIDTH / LIMB;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(WIDTH) + 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, s_q, s_d, t_q, t_d, result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d, c1_q, c1_d, b2_q, b2_d;
    logic              out_valid_q, out_valid_d;
    logic              op_sub, use_t;
    logic [IW-1:0]     lo;
    logic [LIMB-1:0]   la_a, la_b, la_sum;
    logic              la_sub, la_cout;

`ifdef MOD_ADDSUB_SUB_EN
    logic op_q, op_d;
    assign op_sub = (op_q == OP_SUB);
    assign use_t  = op_sub ? c1_q : (c1_q | ~b2_q);
`else
    logic op_unused;
    assign op_unused = op;
    assign op_sub    = 1'b0;
    assign use_t     = c1_q | ~b2_q;
`endif

    limb_addsub #(.LIMB(LIMB)) u_limb (
        .a    (la_a),
        .b    (la_b),
        .sub  (la_sub),
        .cin  (carry_q),
        .sum  (la_sum),
        .cout (la_cout)
    );

    // Pass 1 computes x op y; pass 2 applies the modulus in the opposite direction.
    always_comb begin
        lo     = IW'(cnt_q) * IW'(LIMB);
        la_a   = (state_q == ST_PASS2) ? s_q[lo +: LIMB] : x_q[lo +: LIMB];
        la_b   = (state_q == ST_PASS2) ? MODULUS[lo +: LIMB] : y_q[lo +: LIMB];
        la_sub = (state_q == ST_PASS2) ? ~op_sub : op_sub;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        t_d         = t_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        c1_d        = c1_q;
        b2_d        = b2_q;
        out_valid_d = out_valid_q;
`ifdef MOD_ADDSUB_SUB_EN
        op_d        = op_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
`ifdef MOD_ADDSUB_SUB_EN
                    op_d    = op;
`endif
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_PASS1;
                end
            end
            ST_PASS1: begin
                s_d[lo +: LIMB] = la_sum;
                carry_d         = la_cout;
                cnt_d           = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    c1_d    = la_cout;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_PASS2;
                end
            end
            ST_PASS2: begin
                t_d[lo +: LIMB] = la_sum;
                carry_d         = la_cout;
                cnt_d           = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    b2_d    = la_cout;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle latches the selected result; then hold until taken.
                if (!out_valid_q) begin
                    result_d    = use_t ? t_q : s_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            s_q         <= '0;
            t_q         <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            c1_q        <= 1'b0;
            b2_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MOD_ADDSUB_SUB_EN
            op_q        <= OP_ADD;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            s_q         <= s_d;
            t_q         <= t_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            c1_q        <= c1_d;
            b2_q        <= b2_d;
            out_valid_q <= out_valid_d;
`ifdef MOD_ADDSUB_SUB_EN
            op_q        <= op_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Directed and random checks of mod_addsub_serial against a plain-arithmetic modular model.
module tb_mod_addsub_serial;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
`ifdef MOD_ADDSUB_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, op, out_valid, out_ready, busy;
    logic [255:0] x, y, result;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    mod_addsub_serial dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model(input bit sub, input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        if (sub && HAS_SUB) begin
            s = {1'b0, a} - {1'b0, b};
            if (a < b) s = s + {1'b0, P};
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, P}) s = s - {1'b0, P};
        end
        return s[255:0];
    endfunction

    function automatic logic [255:0] rand_operand();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v >= P) v = v - P;
        return v;
    endfunction

    // Presents one operand set at a negedge; returns just after the accepting edge.
    task automatic start(input string tag, input bit o, input logic [255:0] a, input logic [255:0] b);
        @(negedge clk);
        chk({tag, "_in_ready"}, {255'b0, in_ready}, 256'd1);
        in_valid = 1'b1;
        op = o;
        x = a;
        y = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = '0;
        y = '0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take(input string tag, input logic [255:0] exp);
        chk({tag, "_result"}, result, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ov_after"}, {255'b0, out_valid}, 256'd0);
        chk({tag, "_rdy_after"}, {255'b0, in_ready}, 256'd1);
    endtask

    task automatic run(input string tag, input bit o, input logic [255:0] a,
                       input logic [255:0] b, input logic [255:0] exp);
        int lat;
        start(tag, o, a, b);
        wait_valid(lat);
        chk({tag, "_latency"}, 256'(lat), 256'd9);
        take(tag, exp);
    endtask

    initial begin
        int  lat;
        bit  stray;
        bit  o;
        logic [255:0] a, b;

        reset = 1'b1;
        in_valid = 1'b0;
        op = 1'b0;
        x = '0;
        y = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {255'b0, in_ready}, 256'd1);
        chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
        chk("rst_busy", {255'b0, busy}, 256'd0);
        chk("rst_result", result, 256'd0);
        reset = 1'b0;

        run("add_1_2", 1'b0, 256'd1, 256'd2, 256'd3);
        run("add_pm1_2", 1'b0, P - 256'd1, 256'd2, 256'd1);
        run("add_pm1_1", 1'b0, P - 256'd1, 256'd1, 256'd0);
`ifdef MOD_ADDSUB_SUB_EN
        run("sub_0_1", 1'b1, 256'd0, 256'd1, P - 256'd1);
        run("sub_eq", 1'b1, 256'h1234, 256'h1234, 256'd0);
`else
        run("op_ignored", 1'b1, 256'd9, 256'd4, 256'd13);
`endif

        // Backpressure: result must hold for five stalled cycles.
        start("bp", 1'b0, 256'd10, 256'd20);
        wait_valid(lat);
        chk("bp_latency", 256'(lat), 256'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", {255'b0, out_valid}, 256'd1);
            chk("bp_result", result, 256'd30);
            chk("bp_in_ready", {255'b0, in_ready}, 256'd0);
        end
        take("bp", 256'd30);

        // Operands offered during PASS1 must be ignored.
        start("ign", 1'b0, 256'd100, 256'd200);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        x = 256'd5;
        y = 256'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("ign_latency", 256'(lat), 256'd7);
        take("ign", 256'd300);

        // Reset in the third PASS1 cycle aborts with no output.
        start("abort", 1'b0, 256'd1, 256'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", {255'b0, in_ready}, 256'd1);
        chk("abort_out_valid", {255'b0, out_valid}, 256'd0);
        chk("abort_busy", {255'b0, busy}, 256'd0);
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        chk("abort_no_output", {255'b0, stray}, 256'd0);
        run("add_5_7", 1'b0, 256'd5, 256'd7, 256'd12);

        for (int i = 0; i < 10; i++) begin
            o = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
            a = rand_operand();
            b = (i == 0) ? a : rand_operand();
            run(o ? "rnd_sub" : "rnd_add", o, a, b, model(o, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
